// File: rtl/mixpix_array_ctrl.sv
// mixpix_array_ctrl: Wishbone sequencer for an array of MixPix pixels.
// Starts enabled channels in ascending order and collects their results.
module mixpix_array_ctrl #(
   parameter int NUM_PIX     = 4,
   parameter int DATA_W      = 16,
   parameter int CLK_W       = 10,
   parameter int BASE_NIBBLE = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_stb_i,
   input  logic                      wbs_we_i,
   input  logic [3:0]                wbs_sel_i,
   input  logic [31:0]               wbs_adr_i,
   input  logic [31:0]               wbs_dat_i,
   output logic                      wbs_ack_o,
   output logic [31:0]               wbs_dat_o,
   output logic [NUM_PIX-1:0]        pxl_start_o,
   output logic [CLK_W-1:0]          loc_max_clk_o,
   output logic [CLK_W-1:0]          adj_max_clk_o,
   input  logic [NUM_PIX-1:0]        pxl_done_i,
   input  logic [NUM_PIX*DATA_W-1:0] pxl_data_i,
   output logic                      irq_o
);

   localparam logic [7:0] A_CTRL = 8'h00;
   localparam logic [7:0] A_STAT = 8'h04;
   localparam logic [7:0] A_MASK = 8'h08;
   localparam logic [7:0] A_LOC  = 8'h0C;
   localparam logic [7:0] A_ADJ  = 8'h10;
   localparam logic [7:0] A_TMO  = 8'h14;
   localparam logic [7:0] A_ERR  = 8'h18;
   localparam logic [7:0] A_FCNT = 8'h1C;

   typedef enum logic [1:0] {IDLE, START_CH, WAIT} state_t;

   state_t              state, state_n;
   logic [3:0]          ch, ch_n;
   logic [15:0]         cnt, cnt_n;
   logic                cont, irq_en, done;
   logic [NUM_PIX-1:0]  mask, sh_mask, err, err_set, err_clr;
   logic [CLK_W-1:0]    loc, adj;
   logic [15:0]         tmo, frame_cnt;
   logic [DATA_W-1:0]   result [NUM_PIX];
   logic                acc, wr, start_w, abort_w, done_clr;
   logic                latch, frame_end, cap, cur_done, ev;
   logic [4:0]          nxt, low;
   logic [7:0]          adr;
   logic [31:0]         rdata;
   logic                unused;

   assign adr     = wbs_adr_i[7:0];
   assign acc     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                    (wbs_adr_i[31:28] == 4'(BASE_NIBBLE));
   assign wr      = acc & wbs_we_i & wbs_sel_i[0];
   assign start_w = wr && adr == A_CTRL && wbs_dat_i[0];
   assign abort_w = wr && adr == A_CTRL && wbs_dat_i[3];
   assign done_clr = wr && adr == A_STAT && wbs_dat_i[1];
   assign err_clr = (wr && adr == A_ERR) ? wbs_dat_i[NUM_PIX-1:0] : '0;
   assign irq_o   = done & irq_en;
   assign unused  = ^{wbs_sel_i[3:1], wbs_adr_i[27:8], wbs_dat_i};

   // Lowest set bit of m, optionally restricted to indices above 'above'.
   function automatic logic [4:0] pick(input logic [NUM_PIX-1:0] m,
                                       input logic [3:0] above,
                                       input logic from_lsb);
      logic [4:0] r;
      r = '0;
      for (int i = NUM_PIX - 1; i >= 0; i--)
         if (m[i] && (from_lsb || 4'(i) > above))
            r = {1'b1, 4'(i)};
      return r;
   endfunction

   assign low = pick(mask, 4'd0, 1'b1);
   assign nxt = pick(sh_mask, ch, 1'b0);

   always_comb begin
      cur_done = 1'b0;
      for (int i = 0; i < NUM_PIX; i++)
         if (ch == 4'(i)) cur_done = pxl_done_i[i];
   end

   always_comb begin
      pxl_start_o = '0;
      if (state == START_CH)
         for (int i = 0; i < NUM_PIX; i++)
            if (ch == 4'(i)) pxl_start_o[i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ch    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         ch    <= ch_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      ch_n      = ch;
      cnt_n     = cnt;
      latch     = 1'b0;
      frame_end = 1'b0;
      cap       = 1'b0;
      ev        = 1'b0;
      err_set   = '0;
      if (abort_w) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_w) begin
                  latch = 1'b1;
                  if (low[4]) begin
                     state_n = START_CH;
                     ch_n    = low[3:0];
                  end else begin
                     frame_end = 1'b1;
                  end
               end
            end
            START_CH: begin
               cnt_n   = '0;
               state_n = WAIT;
            end
            WAIT: begin
               cnt_n = cnt + 16'd1;
               if (cur_done) begin
                  cap = 1'b1;
                  ev  = 1'b1;
               end else if (tmo != 16'd0 &&
                            ({1'b0, cnt} + 17'd1) == {1'b0, tmo}) begin
                  ev = 1'b1;
                  for (int i = 0; i < NUM_PIX; i++)
                     if (ch == 4'(i)) err_set[i] = 1'b1;
               end
               if (ev) begin
                  if (nxt[4]) begin
                     state_n = START_CH;
                     ch_n    = nxt[3:0];
                  end else begin
                     frame_end = 1'b1;
                     state_n   = IDLE;
                     if (cont) begin
                        latch = 1'b1;
                        if (low[4]) begin
                           state_n = START_CH;
                           ch_n    = low[3:0];
                        end
                     end
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cont          <= 1'b0;
         irq_en        <= 1'b0;
         done          <= 1'b0;
         mask          <= '0;
         sh_mask       <= '0;
         loc           <= '0;
         adj           <= '0;
         tmo           <= '0;
         err           <= '0;
         frame_cnt     <= '0;
         loc_max_clk_o <= '0;
         adj_max_clk_o <= '0;
         for (int i = 0; i < NUM_PIX; i++) result[i] <= '0;
      end else begin
         if (wr) begin
            case (adr)
               A_CTRL: begin
                  cont   <= wbs_dat_i[1];
                  irq_en <= wbs_dat_i[2];
               end
               A_MASK: mask <= wbs_dat_i[NUM_PIX-1:0];
               A_LOC:  loc  <= wbs_dat_i[CLK_W-1:0];
               A_ADJ:  adj  <= wbs_dat_i[CLK_W-1:0];
               A_TMO:  tmo  <= wbs_dat_i[15:0];
               default: ;
            endcase
         end
         // Hardware set beats a same-cycle W1C.
         done <= (done & ~done_clr) | frame_end;
         err  <= (err & ~err_clr) | err_set;
         if (frame_end) frame_cnt <= frame_cnt + 16'd1;
         if (latch) begin
            sh_mask       <= mask;
            loc_max_clk_o <= loc;
            adj_max_clk_o <= adj;
         end
         for (int i = 0; i < NUM_PIX; i++)
            if (cap && ch == 4'(i))
               result[i] <= pxl_data_i[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      rdata = '0;
      case (adr)
         A_CTRL: rdata = {29'd0, irq_en, cont, 1'b0};
         A_STAT: rdata = {20'd0, ch, 6'd0, done, state != IDLE};
         A_MASK: rdata = 32'(mask);
         A_LOC:  rdata = 32'(loc);
         A_ADJ:  rdata = 32'(adj);
         A_TMO:  rdata = {16'd0, tmo};
         A_ERR:  rdata = 32'(err);
         A_FCNT: rdata = {16'd0, frame_cnt};
         default: begin
            if (adr[7:6] == 2'b01 && adr[1:0] == 2'b00)
               for (int i = 0; i < NUM_PIX; i++)
                  if (adr[5:2] == 4'(i)) rdata = 32'(result[i]);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= acc;
         wbs_dat_o <= (acc && !wbs_we_i) ? rdata : 32'd0;
      end
   end

endmodule

// File: tb/tb_mixpix_array_ctrl.sv
// tb_mixpix_array_ctrl: directed vectors and pixel-model sequences
// for the MixPix array sequencer.
module tb_mixpix_array_ctrl;

   localparam int NP = 4;
   localparam int DW = 16;
   localparam int CW = 10;
   localparam logic [31:0] B = 32'h3000_0000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cyc_i = 0, stb_i = 0, we_i = 0;
   logic [3:0]       sel_i = '0;
   logic [31:0]      adr_i = '0, dat_i = '0;
   logic             ack;
   logic [31:0]      dat_o;
   logic [NP-1:0]    pxl_start;
   logic [CW-1:0]    loc_o, adj_o;
   logic [NP-1:0]    pxl_done;
   logic [NP*DW-1:0] pxl_data;
   logic             irq;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_acc = 0;
   int pcnt [NP] = '{default: 0};
   int pcyc [NP] = '{default: 0};
   int age  [NP] = '{default: 0};
   int dly  [NP] = '{default: 3};
   logic hold [NP] = '{default: 1'b0};
   logic [DW-1:0] pdat [NP] = '{default: '0};

   always #5 clk = ~clk;

   mixpix_array_ctrl #(
      .NUM_PIX(NP), .DATA_W(DW), .CLK_W(CW), .BASE_NIBBLE(3)
   ) dut (
      .clk(clk), .rst(rst),
      .wbs_cyc_i(cyc_i), .wbs_stb_i(stb_i), .wbs_we_i(we_i),
      .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
      .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .pxl_start_o(pxl_start),
      .loc_max_clk_o(loc_o), .adj_max_clk_o(adj_o),
      .pxl_done_i(pxl_done), .pxl_data_i(pxl_data),
      .irq_o(irq)
   );

   // Pixel model: done rises dly cycles after the start pulse.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NP; i++) begin
         if (pxl_start[i]) begin
            pcnt[i] <= pcnt[i] + 1;
            pcyc[i] <= cyc;
            age[i]  <= 1;
         end else if (age[i] != 0) begin
            age[i] <= age[i] + 1;
         end
      end
   end

   always_comb begin
      pxl_done = '0;
      pxl_data = '0;
      for (int i = 0; i < NP; i++) begin
         pxl_done[i] = hold[i] | (dly[i] != 0 && age[i] == dly[i]);
         pxl_data[i*DW +: DW] = pdat[i];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wb(input logic [31:0] a, input logic we,
                     input logic [31:0] d, input logic [3:0] sel,
                     output logic k, output logic [31:0] rd);
      @(negedge clk);
      cyc_i = 1; stb_i = 1; we_i = we;
      adr_i = a; dat_i = d; sel_i = sel;
      last_acc = cyc;
      @(posedge clk);
      @(negedge clk);
      k  = ack;
      rd = dat_o;
      cyc_i = 0; stb_i = 0; we_i = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic k;
      logic [31:0] rd;
      wb(B | 32'(a), 1'b1, d, 4'hF, k, rd);
      chk($sformatf("wr ack %02h", a), 32'(k), 32'd1);
   endtask

   task automatic rdc(input logic [7:0] a, input logic [31:0] e);
      logic k;
      logic [31:0] rd;
      wb(B | 32'(a), 1'b0, 32'd0, 4'hF, k, rd);
      chk($sformatf("rd ack %02h", a), 32'(k), 32'd1);
      chk($sformatf("rd %02h", a), rd, e);
   endtask

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        ack;
      logic [31:0] rdat;
   } vec_t;

   vec_t tbl [$];

   initial begin
      #200000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int b [NP];
      logic k;
      logic [31:0] rd;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst outs", {ack, dat_o != 0, pxl_start, irq, loc_o != 0,
          adj_o != 0}, 32'd0);

      tbl.push_back('{B | 32'h04, 0, 4'hF, 0, 1, 32'h0});
      tbl.push_back('{B | 32'h1C, 0, 4'hF, 0, 1, 32'h0});
      tbl.push_back('{B | 32'h40, 0, 4'hF, 0, 1, 32'h0});
      tbl.push_back('{B | 32'h4C, 0, 4'hF, 0, 1, 32'h0});
      tbl.push_back('{32'h2000_0004, 0, 4'hF, 0, 0, 32'h0});
      tbl.push_back('{B | 32'h20, 0, 4'hF, 0, 1, 32'h0});
      tbl.push_back('{B | 32'h50, 0, 4'hF, 0, 1, 32'h0});
      tbl.push_back('{B | 32'h08, 1, 4'hF, 32'hFF, 1, 32'h0});
      tbl.push_back('{B | 32'h08, 0, 4'hF, 0, 1, 32'hF});
      tbl.push_back('{B | 32'h08, 1, 4'hE, 32'h3, 1, 32'h0});
      tbl.push_back('{B | 32'h08, 0, 4'hF, 0, 1, 32'hF});
      tbl.push_back('{32'h2000_0008, 1, 4'hF, 32'h1, 0, 32'h0});
      tbl.push_back('{B | 32'h08, 0, 4'hF, 0, 1, 32'hF});
      tbl.push_back('{B | 32'h0C, 1, 4'hF, 32'hFFFF, 1, 32'h0});
      tbl.push_back('{B | 32'h0C, 0, 4'hF, 0, 1, 32'h3FF});
      tbl.push_back('{B | 32'h10, 1, 4'hF, 32'h155, 1, 32'h0});
      tbl.push_back('{B | 32'h10, 0, 4'hF, 0, 1, 32'h155});
      tbl.push_back('{B | 32'h14, 1, 4'hF, 32'h12345, 1, 32'h0});
      tbl.push_back('{B | 32'h14, 0, 4'hF, 0, 1, 32'h2345});
      tbl.push_back('{B | 32'h00, 1, 4'hF, 32'h6, 1, 32'h0});
      tbl.push_back('{B | 32'h00, 0, 4'hF, 0, 1, 32'h6});
      tbl.push_back('{B | 32'h00, 1, 4'hF, 32'h0, 1, 32'h0});
      tbl.push_back('{B | 32'h00, 0, 4'hF, 0, 1, 32'h0});

      foreach (tbl[i]) begin
         wb(tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].sel, k, rd);
         chk($sformatf("vec%0d ack", i), 32'(k), 32'(tbl[i].ack));
         if (!tbl[i].we && tbl[i].ack)
            chk($sformatf("vec%0d data", i), rd, tbl[i].rdat);
      end
      chk("shadow loc idle", 32'(loc_o), 32'd0);
      chk("shadow adj idle", 32'(adj_o), 32'd0);
      wr(8'h0C, 0);
      wr(8'h10, 0);
      wr(8'h14, 0);

      // Frame over channels 0,1,3
      pdat[0] = 16'h1111; pdat[1] = 16'h2222;
      pdat[2] = 16'h3333; pdat[3] = 16'h4444;
      wr(8'h08, 32'hB);
      for (int i = 0; i < NP; i++) b[i] = pcnt[i];
      wr(8'h00, 32'h5);
      n = last_acc;
      repeat (11) @(negedge clk);
      chk("irq before end", 32'(irq), 32'd0);
      @(negedge clk);
      chk("irq at end", 32'(irq), 32'd1);
      chk("A pulse0 cyc", pcyc[0], n + 1);
      chk("A pulse1 cyc", pcyc[1], n + 5);
      chk("A pulse3 cyc", pcyc[3], n + 9);
      chk("A pulses", {8'(pcnt[0] - b[0]), 8'(pcnt[1] - b[1]),
          8'(pcnt[2] - b[2]), 8'(pcnt[3] - b[3])}, 32'h01010001);
      rdc(8'h40, 32'h1111);
      rdc(8'h44, 32'h2222);
      rdc(8'h48, 32'h0);
      rdc(8'h4C, 32'h4444);
      rdc(8'h04, 32'h302);
      rdc(8'h1C, 32'd1);
      wr(8'h04, 32'h2);
      chk("irq after w1c", 32'(irq), 32'd0);

      // Timeout on channel 1
      dly[1] = 0;
      pdat[1] = 16'h5555; pdat[3] = 16'h6666;
      wr(8'h14, 32'd5);
      wr(8'h00, 32'h1);
      n = last_acc;
      repeat (20) @(negedge clk);
      chk("B pulse1 cyc", pcyc[1], n + 5);
      chk("B pulse3 cyc", pcyc[3], n + 11);
      rdc(8'h18, 32'h2);
      rdc(8'h44, 32'h2222);
      rdc(8'h4C, 32'h6666);
      rdc(8'h1C, 32'd2);
      wr(8'h18, 32'h2);
      rdc(8'h18, 32'h0);
      wr(8'h14, 32'd0);
      dly[1] = 3;

      // Continuous single-channel frames
      hold[0] = 1'b1;
      wr(8'h08, 32'h1);
      b[0] = pcnt[0];
      wr(8'h00, 32'h3);
      n = last_acc;
      repeat (10) @(negedge clk);
      chk("C pulses mid", pcnt[0] - b[0], 32'd5);
      chk("C pulse spacing", pcyc[0], n + 9);
      wr(8'h00, 32'h0);
      repeat (12) @(negedge clk);
      chk("C pulses total", pcnt[0] - b[0], 32'd7);
      rdc(8'h1C, 32'd9);
      rdc(8'h04, 32'h002);
      hold[0] = 1'b0;

      // Abort while waiting on channel 2
      dly[2] = 0;
      wr(8'h04, 32'h2);
      wr(8'h08, 32'hF);
      wr(8'h00, 32'h1);
      repeat (9) @(negedge clk);
      rdc(8'h04, 32'h201);
      for (int i = 0; i < NP; i++) b[i] = pcnt[i];
      wr(8'h00, 32'h8);
      repeat (10) @(negedge clk);
      chk("D no pulses", (pcnt[2] - b[2]) + (pcnt[3] - b[3]), 32'd0);
      rdc(8'h04, 32'h200);
      rdc(8'h1C, 32'd9);
      wr(8'h00, 32'h9);
      repeat (4) @(negedge clk);
      chk("D start+abort", pcnt[0] - b[0], 32'd0);
      rdc(8'h04, 32'h200);
      dly[2] = 3;

      // Empty mask, then shadowed limit update
      wr(8'h0C, 32'h55);
      wr(8'h08, 32'h0);
      b[0] = pcnt[0];
      wr(8'h00, 32'h1);
      chk("E loc latched", 32'(loc_o), 32'h55);
      rdc(8'h04, 32'h202);
      rdc(8'h1C, 32'd10);
      chk("E no pulses", pcnt[0] - b[0], 32'd0);
      wr(8'h08, 32'h1);
      wr(8'h00, 32'h1);
      wr(8'h0C, 32'h77);
      chk("E loc mid frame", 32'(loc_o), 32'h55);
      repeat (5) @(negedge clk);
      wr(8'h00, 32'h1);
      chk("E loc next frame", 32'(loc_o), 32'h77);
      repeat (6) @(negedge clk);
      rdc(8'h1C, 32'd12);

      // Reset in the middle of a frame
      wr(8'h00, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("R outs", {pxl_start, irq, loc_o != 0, ack}, 32'd0);
      rdc(8'h1C, 32'd0);
      rdc(8'h08, 32'd0);
      rdc(8'h40, 32'd0);
      rdc(8'h04, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
